turf_tally_scanner: RTL and testbench
=====================================

Name: turf_tally_scanner

Overview:
- Parametrised end-of-round scorer for the turf framebuffer. On a start pulse it reads every framebuffer cell once through a RAM read port with fixed latency, counts cells per player colour, and then picks the winner.
- Sits between the framebuffer RAM read port and the score/winner display logic. It is active only while the game is not running.
- Generalises the earlier fixed 4-player scan with: N players, configurable colour codes, configurable RAM latency, explicit start/busy/done handshake, saturating counters, and a reported tie flag.

Parameters:
- NUM_PLAYERS, 4, number of players/colours counted (2..8).
- COLOR_W, 3, width of one framebuffer cell.
- ADDR_W, 15, framebuffer address width ({x[7:0], y[6:0]} packing).
- LAST_ADDR, 15'h4F7F, final linear address scanned; the scan covers 0..LAST_ADDR inclusive.
- RD_LAT, 1, RAM read latency in cycles (1..3).
- CNT_W, 15, width of each per-player counter.
- COLORS, {3'b110,3'b100,3'b010,3'b001}, packed NUM_PLAYERS*COLOR_W colour codes; slice i is the colour of player i.
- WIN_W, 2, winner index width (>= clog2(NUM_PLAYERS)).

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a scan; sampled only in IDLE.
- ram_addr  out  ADDR_W  framebuffer read address.
- ram_rd_en  out  1  read strobe; high for each issued address.
- ram_data  in  COLOR_W  read data, valid RD_LAT cycles after the matching ram_rd_en.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when results are final.
- counts  out  NUM_PLAYERS*CNT_W  packed per-player cell counts; slice i belongs to player i.
- winner  out  WIN_W  index of the winning player.
- tie  out  1  high if more than one player holds the maximum count.

Behaviour:
- Reset:
  - state goes to IDLE.
  - ram_addr=0, ram_rd_en=0, busy=0, done=0.
  - all counts=0, winner=0, tie=0.
  - the read-valid pipeline is cleared.
  - Reset asserted mid-scan aborts the scan with no done pulse; any in-flight RAM data is discarded.
- States: IDLE -> SCAN -> DRAIN -> COMPARE -> DONE -> IDLE.
- IDLE:
  - start=1 clears all counts, winner and tie, sets ram_addr=0, and moves to SCAN.
  - Results from the previous scan are held until the next accepted start.
- SCAN:
  - ram_rd_en=1 every cycle; ram_addr increments by 1 each cycle from 0.
  - When ram_addr==LAST_ADDR is issued, the next state is DRAIN.
  - ram_addr never exceeds LAST_ADDR.
- Valid pipeline:
  - ram_rd_en is delayed through an RD_LAT-deep valid shift register.
  - When the delayed valid is high, ram_data is compared against every COLORS slice.
  - On a match, that player's counter increments. A matching counter already at all-ones holds (saturates).
  - A value matching no colour (e.g. 3'b000, unpainted) is ignored.
  - If a colour appears in two slices, the lowest index wins.
- DRAIN:
  - ram_rd_en=0; the block waits exactly RD_LAT cycles so the last datum is counted.
  - It then moves to COMPARE.
- COMPARE:
  - Sequential, one player per cycle, NUM_PLAYERS cycles.
  - The running best starts at player 0.
  - Player i replaces the best only if count_i > best (strictly greater), so ties resolve to the lowest index.
  - tie is set if any player's count equals the final maximum and that player's index is not the winner's.
- DONE:
  - done=1 for exactly one cycle; busy drops in the same cycle; next state is IDLE.
- start asserted while busy is ignored and not queued.
- Latency: done is high exactly (LAST_ADDR+1) + RD_LAT + NUM_PLAYERS + 1 cycles after the edge that sampled start=1 in IDLE.
- No combinational path from start or ram_data to any output.

Test Plan:
- Reset then idle: hold reset 2 cycles, release with start=0 -> all outputs 0, ram_rd_en never rises.
- Small map, clear winner: LAST_ADDR=15, RD_LAT=1; RAM holds 8 cells 3'b001, 4 cells 3'b010, 3 cells 3'b100, 1 cell 3'b000; pulse start -> counts = {0,3,4,8}, winner=0, tie=0, done after 16+1+4+1=22 cycles.
- Tie: RAM holds 6 cells 3'b010 and 6 cells 3'b110, rest 3'b000 -> winner=1, tie=1.
- Latency sweep: RD_LAT=3 with the same data as the small-map case -> identical counts; done at cycle 24; the last cell is counted (flip cell 15's colour and confirm its counter changes).
- Saturation: CNT_W=3, all 16 cells 3'b001 -> p0 count=7 and holds, winner=0.
- Abort and ignore: pulse start again at cycle 5 -> ignored. Assert reset at cycle 10 -> IDLE with counts=0 and no done. Fresh start -> normal result.

Source files
------------

// File: rtl/turf_tally_scanner.sv
// turf_tally_scanner
// End-of-round scorer for the turf framebuffer. It reads each cell once
// through a fixed-latency RAM read port and counts the cells of each player
// colour. It then compares the counters one player per cycle to select the
// winner and to flag a tie. Every output is driven directly from a register.
module turf_tally_scanner #(
    parameter int                             NUM_PLAYERS = 4,
    parameter int                             COLOR_W     = 3,
    parameter int                             ADDR_W      = 15,
    parameter logic [ADDR_W-1:0]              LAST_ADDR   = 15'h4F7F,
    parameter int                             RD_LAT      = 1,
    parameter int                             CNT_W       = 15,
    parameter logic [NUM_PLAYERS*COLOR_W-1:0] COLORS      = {3'b110, 3'b100, 3'b010, 3'b001},
    parameter int                             WIN_W       = 2
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         start,
    output logic [ADDR_W-1:0]            ram_addr,
    output logic                         ram_rd_en,
    input  logic [COLOR_W-1:0]           ram_data,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_PLAYERS*CNT_W-1:0] counts,
    output logic [WIN_W-1:0]             winner,
    output logic                         tie
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SCAN    = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_COMPARE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_en_q, rd_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [1:0]        drain_q, drain_d;
    logic [WIN_W-1:0]  cmp_idx_q, cmp_idx_d;
    logic [WIN_W-1:0]  winner_q, winner_d;
    logic [CNT_W-1:0]  best_q, best_d;
    logic              tie_q, tie_d;
    logic [CNT_W-1:0]  cnt_q [NUM_PLAYERS];
    logic [CNT_W-1:0]  cnt_d [NUM_PLAYERS];

    logic              hit;
    logic [WIN_W-1:0]  hit_idx;
    logic [CNT_W-1:0]  cmp_cnt;

    // Colour decode: scanning downward lets the lowest matching slice win.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (ram_data == COLORS[i*COLOR_W +: COLOR_W]) begin
                hit     = 1'b1;
                hit_idx = WIN_W'(i);
            end
        end
    end

    assign cmp_cnt = cnt_q[cmp_idx_q];

    // Next-state logic for the scan FSM, the counters and the running comparison.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        addr_d    = addr_q;
        rd_en_d   = rd_en_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        drain_d   = drain_q;
        cmp_idx_d = cmp_idx_q;
        winner_d  = winner_q;
        best_d    = best_q;
        tie_d     = tie_q;
        vld_d     = vld_q << 1;
        vld_d[0]  = rd_en_q;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        // Count the returning datum; a counter that is already all-ones holds.
        if (vld_q[RD_LAT-1] && hit && (cnt_q[hit_idx] != '1)) begin
            cnt_d[hit_idx] = cnt_q[hit_idx] + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        cnt_d[i] = '0;
                    end
                    winner_d = '0;
                    tie_d    = 1'b0;
                    addr_d   = '0;
                    rd_en_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (addr_q == LAST_ADDR) begin
                    rd_en_d = 1'b0;
                    drain_d = 2'd0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == 2'(RD_LAT - 1)) begin
                    cmp_idx_d = '0;
                    state_d   = S_COMPARE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            S_COMPARE: begin
                // Only a strictly greater count replaces the best, so a tie keeps the lower index.
                if (cmp_idx_q == '0) begin
                    best_d   = cmp_cnt;
                    winner_d = '0;
                    tie_d    = 1'b0;
                end else if (cmp_cnt > best_q) begin
                    best_d   = cmp_cnt;
                    winner_d = cmp_idx_q;
                    tie_d    = 1'b0;
                end else if (cmp_cnt == best_q) begin
                    tie_d = 1'b1;
                end
                if (cmp_idx_q == WIN_W'(NUM_PLAYERS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cmp_idx_d = cmp_idx_q + WIN_W'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; a reset during a scan discards it.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            vld_q     <= '0;
            drain_q   <= 2'd0;
            cmp_idx_q <= '0;
            winner_q  <= '0;
            best_q    <= '0;
            tie_q     <= 1'b0;
            // NOTE: the counter array is a small register file that drives the outputs, so it is reset.
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rd_en_q   <= rd_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            vld_q     <= vld_d;
            drain_q   <= drain_d;
            cmp_idx_q <= cmp_idx_d;
            winner_q  <= winner_d;
            best_q    <= best_d;
            tie_q     <= tie_d;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_counts
        assign counts[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign ram_addr  = addr_q;
    assign ram_rd_en = rd_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign winner    = winner_q;
    assign tie       = tie_q;

endmodule

// File: tb/tb_turf_tally_scanner.sv
// tb_turf_tally_scanner
// Three scanner instances run on a shared 16-cell map and share the start and
// reset inputs. They differ in read latency, counter width and colour table.
// A reference model fills per-instance scoreboard queues at each start, and a
// monitor for each instance checks the results whenever its done output pulses.
module tb_turf_tally_scanner;

    typedef struct packed {
        logic [59:0] counts;
        logic [1:0]  winner;
        logic        tie;
        int          t0;
    } exp_t;

    localparam int          RL_C     [3] = '{1, 3, 1};
    localparam int          CW_C     [3] = '{15, 15, 3};
    localparam logic [11:0] COLORS_C [3] = '{12'o6421, 12'o6421, 12'o1421};

    logic clk;
    logic reset;
    logic start;
    logic [2:0] mem [16];
    int   cyc;
    bit   idle_chk;
    int   n_checks;
    int   n_errors;
    exp_t sbq [3][$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: tally each cell under the first matching colour, cap the tally, then take the maximum.
    function automatic exp_t model(input int k);
        exp_t        e;
        int          cnt [4];
        int          cap;
        int          mx;
        int          nmax;
        logic [11:0] cl;
        bit          found;
        cl  = COLORS_C[k];
        cap = (1 << CW_C[k]) - 1;
        for (int p = 0; p < 4; p++) cnt[p] = 0;
        for (int c = 0; c < 16; c++) begin
            found = 1'b0;
            for (int p = 0; p < 4; p++) begin
                if (!found && mem[c] == cl[p*3 +: 3]) begin
                    found = 1'b1;
                    if (cnt[p] < cap) cnt[p]++;
                end
            end
        end
        mx = 0;
        for (int p = 0; p < 4; p++) if (cnt[p] > mx) mx = cnt[p];
        nmax     = 0;
        e        = '0;
        e.winner = 2'd0;
        for (int p = 3; p >= 0; p--) begin
            if (cnt[p] == mx) begin
                nmax++;
                e.winner = 2'(p);
            end
        end
        e.tie = (nmax > 1);
        for (int p = 0; p < 4; p++) e.counts[p*15 +: 15] = 15'(cnt[p]);
        return e;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_cfg
        localparam int          RL = RL_C[k];
        localparam int          CW = CW_C[k];
        localparam logic [11:0] CL = COLORS_C[k];

        logic [14:0]   addr;
        logic          rd_en;
        logic [2:0]    rdata;
        logic          busy;
        logic          done;
        logic [4*CW-1:0] cnt_o;
        logic [1:0]    win;
        logic          tie;
        logic [2:0]    pipe [3];
        bit            rst_seen;

        turf_tally_scanner #(
            .NUM_PLAYERS(4),
            .COLOR_W    (3),
            .ADDR_W     (15),
            .LAST_ADDR  (15'd15),
            .RD_LAT     (RL),
            .CNT_W      (CW),
            .COLORS     (CL),
            .WIN_W      (2)
        ) u_dut (
            .CLOCK_50 (clk),
            .reset    (reset),
            .start    (start),
            .ram_addr (addr),
            .ram_rd_en(rd_en),
            .ram_data (rdata),
            .busy     (busy),
            .done     (done),
            .counts   (cnt_o),
            .winner   (win),
            .tie      (tie)
        );

        // RAM read port with RL cycles of latency; returns junk when no read is issued.
        always @(posedge clk) begin
            pipe[0] <= rd_en ? mem[addr[3:0]] : 3'($urandom);
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign rdata = pipe[RL-1];

        always @(posedge clk) rst_seen <= reset;

        initial begin
            int          ea;
            exp_t        e;
            logic [59:0] act;
            ea = 0;
            forever begin
                @(negedge clk);
                act = '0;
                for (int p = 0; p < 4; p++) act[p*15 +: 15] = 15'(cnt_o[p*CW +: CW]);
                if (rst_seen) begin
                    check({addr, rd_en, busy, done, cnt_o, win, tie} == '0, "reset_state",
                          longint'({addr, rd_en, busy, done, win, tie}) | longint'(act != 0), 0);
                end else if (idle_chk) begin
                    check({rd_en, busy, done, cnt_o, win, tie} == '0, "idle_quiet",
                          longint'({rd_en, busy, done, win, tie}) | longint'(act != 0), 0);
                end
                if (rd_en) begin
                    check(addr == 15'(ea), "rd_addr", longint'(addr), ea);
                    ea++;
                end else if (ea != 0) begin
                    if (!reset) check(ea == 16, "rd_count", ea, 16);
                    ea = 0;
                end
                if (done && !reset) begin
                    check(sbq[k].size() != 0, "done_expected", 1, 0);
                    if (sbq[k].size() != 0) begin
                        e = sbq[k].pop_front();
                        check(act == e.counts, "counts", longint'(act), longint'(e.counts));
                        check(win == e.winner, "winner", longint'(win), longint'(e.winner));
                        check(tie == e.tie, "tie", longint'(tie), longint'(e.tie));
                        check(cyc - e.t0 == 16 + RL + 4 + 1, "latency", cyc - e.t0, 16 + RL + 4 + 1);
                        check(busy == 1'b0, "busy_at_done", longint'(busy), 0);
                    end
                end
            end
        end
    end

    task automatic run_scan();
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e    = model(k);
            e.t0 = cyc + 1;
            sbq[k].push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_all();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 200 && !empty; i++) begin
            @(negedge clk);
            empty = (sbq[0].size() == 0) && (sbq[1].size() == 0) && (sbq[2].size() == 0);
        end
        check(empty, "done_timeout", longint'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 0);
        repeat (2) @(negedge clk);
    endtask

    // Fill the map with the given number of cells of each colour (the rest unpainted), shuffled.
    task automatic fill_mix(input int n1, input int n2, input int n4, input int n6);
        int         idx;
        int         j;
        logic [2:0] tmp;
        idx = 0;
        for (int i = 0; i < 16; i++) mem[i] = 3'b000;
        for (int i = 0; i < n1; i++) begin mem[idx] = 3'b001; idx++; end
        for (int i = 0; i < n2; i++) begin mem[idx] = 3'b010; idx++; end
        for (int i = 0; i < n4; i++) begin mem[idx] = 3'b100; idx++; end
        for (int i = 0; i < n6; i++) begin mem[idx] = 3'b110; idx++; end
        for (int i = 15; i > 0; i--) begin
            j      = $urandom_range(0, i);
            tmp    = mem[i];
            mem[i] = mem[j];
            mem[j] = tmp;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        reset    = 1'b1;
        start    = 1'b0;
        idle_chk = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 3'b000;

        repeat (2) @(negedge clk);
        reset    = 1'b0;
        idle_chk = 1'b1;
        repeat (20) @(negedge clk);
        idle_chk = 1'b0;

        // Clear winner, tie, and last-cell flips.
        fill_mix(8, 4, 3, 0);
        run_scan();
        wait_all();
        fill_mix(0, 6, 0, 6);
        run_scan();
        wait_all();
        mem[15] = 3'b001;
        run_scan();
        wait_all();
        mem[15] = 3'b100;
        run_scan();
        wait_all();

        // Saturation: every cell belongs to player 0.
        fill_mix(16, 0, 0, 0);
        run_scan();
        wait_all();

        // Random maps.
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 16; i++) mem[i] = 3'($urandom_range(0, 7));
            run_scan();
            wait_all();
        end

        // A start during busy is ignored; a reset mid-scan aborts without done.
        fill_mix(5, 5, 2, 4);
        run_scan();
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) sbq[k].delete();
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        idle_chk = 1'b1;
        repeat (30) @(negedge clk);
        idle_chk = 1'b0;
        run_scan();
        wait_all();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
